md_unit_param: RTL and testbench
================================

Name: md_unit_param

Overview:
Parametrised successor to the pipeline's multiply/divide unit. It sits in EX beside the ALU and takes operands after forwarding. It holds the architectural HI/LO registers and executes multiply, divide, multiply-accumulate and move-to-HI/LO with independently configurable latencies. It reports busy and stall status to the hazard logic, and supports flushing an in-flight operation on exception or branch squash.

Parameters:
WIDTH, 32, operand and HI/LO width; legal range 8 to 64.
MUL_CYCLES, 5, cycles busy is held for MULT/MULTU/MADD*/MSUB*; minimum 1.
DIV_CYCLES, 10, cycles busy is held for DIV/DIVU; minimum 1.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  request; qualifies op, src_a and src_b this cycle
op  in  4  operation code, encoded by the MD_OP_* constants
src_a  in  WIDTH  rs operand (dividend / multiplicand)
src_b  in  WIDTH  rt operand (divisor / multiplier)
flush  in  1  abort any in-flight operation
busy  out  1  registered; high while an operation is in flight
stall_req  out  1  combinational: busy | (start & op is a multi-cycle op)
done  out  1  registered one-cycle pulse when HI/LO commit
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, any time): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, pending result discarded.
- States are IDLE and RUN.
- IDLE with start and a multi-cycle op at edge E0:
  - capture the computed {hi,lo} into pending registers;
  - load counter with MUL_CYCLES or DIV_CYCLES; state becomes RUN; busy=1.
- RUN: counter decrements on each edge. At the edge where the counter reaches 0:
  - hi/lo take the pending value; busy=0; done=1 for one cycle; state becomes IDLE.
  - So busy is high for exactly N cycles, and new hi/lo are visible in the cycle after busy falls.
- MTHI/MTLO in IDLE: the target register is written at the next edge. No busy, no done; the other register is unchanged.
- start while busy: ignored, and no state change. The hazard logic must stall on stall_req, so this must not occur; the bench flags it.
- start with an undefined op: ignored.
- Back-to-back: start may be accepted in the same cycle done is high, because the FSM is IDLE that cycle.
- flush:
  - in RUN: next edge returns to IDLE, busy=0, hi/lo unchanged, no done;
  - in IDLE: suppresses start and MTHI/MTLO that cycle;
  - flush and the final count in the same cycle: flush wins, no commit.
- MULT (signed) and MULTU: full 2*WIDTH product; hi=upper, lo=lower.
- MADD/MADDU/MSUB/MSUBU: {hi,lo} ± product, wrapping mod 2^(2*WIDTH). The accumulate base is the {hi,lo} value at start acceptance.
- DIV/DIVU: lo=quotient, hi=remainder. Signed results truncate toward zero; the remainder takes the dividend's sign.
- Divide by zero (both DIV and DIVU): lo=all-ones, hi=src_a.
- DIV signed overflow (min_int / -1): lo=min_int, hi=0.
- No outputs depend combinationally on the operands. stall_req depends only on start, op and busy.

Decomposition:
- Shared header md_defines: MD_OP_* codes (MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO) and MD_IDLE/MD_RUN state codes. The EX controller includes the same header.
- One natural sub-module, md_calc: purely combinational. Inputs are op, src_a, src_b and the current {hi,lo}; output is the 2*WIDTH next {hi,lo}, including the divide corner cases.
- md_unit_param holds the FSM, counter, pending registers, flush handling and HI/LO.

Test Plan (WIDTH=32, MUL_CYCLES=5, DIV_CYCLES=10):
1. After reset, MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi=0x12345678, lo=0x9ABCDEF0 one cycle later each; busy stays 0.
2. MULT 0xFFFFFFFE×3 -> busy high 5 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA. Then MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV 0xFFFFFFF9 (-7) / 2 -> busy high 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
4. Corner cases:
   - DIV 5/0 -> lo=0xFFFFFFFF, hi=5;
   - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0;
   - with hi:lo=0:0xFFFFFFFF, MADDU 1×1 -> hi=1, lo=0.
5. Flush and illegal start:
   - start DIV, assert flush in the 3rd busy cycle -> busy=0 next cycle, no done, hi/lo keep their prior values;
   - start asserted while busy -> ignored, and the result of the first op is correct.
6. Async reset asserted mid-MULT, between clock edges -> busy, hi and lo go to 0 immediately. After release, a new MULT 6×7 gives lo=42, hi=0.

Source files
------------

// File: rtl/md_unit_param_pkg.sv
// md_unit_param_pkg: opcodes, FSM state type and op classification helpers for the multiply/divide unit
package md_unit_param_pkg;

    localparam logic [3:0] MD_OP_MULT  = 4'd0;
    localparam logic [3:0] MD_OP_MULTU = 4'd1;
    localparam logic [3:0] MD_OP_DIV   = 4'd2;
    localparam logic [3:0] MD_OP_DIVU  = 4'd3;
    localparam logic [3:0] MD_OP_MADD  = 4'd4;
    localparam logic [3:0] MD_OP_MADDU = 4'd5;
    localparam logic [3:0] MD_OP_MSUB  = 4'd6;
    localparam logic [3:0] MD_OP_MSUBU = 4'd7;
    localparam logic [3:0] MD_OP_MTHI  = 4'd8;
    localparam logic [3:0] MD_OP_MTLO  = 4'd9;

    typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

    // All multi-cycle ops occupy the low codes 0..7
    function automatic logic md_is_multi(input logic [3:0] op);
        return op <= MD_OP_MSUBU;
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return op == MD_OP_DIV || op == MD_OP_DIVU;
    endfunction

    function automatic logic md_is_mt(input logic [3:0] op);
        return op == MD_OP_MTHI || op == MD_OP_MTLO;
    endfunction

endpackage

// File: rtl/md_unit_param_calc.sv
// md_unit_param_calc: combinational next-{hi,lo} for every opcode, including divide corner cases
module md_unit_param_calc
    import md_unit_param_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [2*WIDTH-1:0] hilo_i,
    output logic [2*WIDTH-1:0] hilo_o
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    prod_s, prod_u;
    logic [WIDTH-1:0] abs_a, abs_b, div_bu, div_bs;
    logic [WIDTH-1:0] uq, ur, mq, mr, sq, sr;

    // Low 2W bits of a product of sign-extended operands equal the signed product
    assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Divisors forced non-zero so the dividers never see zero; that case is muxed out below
    assign div_bu = (b_i == '0) ? WIDTH'(1) : b_i;
    assign uq     = a_i / div_bu;
    assign ur     = a_i % div_bu;

    // Signed divide on magnitudes; min_int / -1 naturally yields quotient min_int, remainder 0
    assign abs_a  = a_i[WIDTH-1] ? -a_i : a_i;
    assign abs_b  = b_i[WIDTH-1] ? -b_i : b_i;
    assign div_bs = (abs_b == '0) ? WIDTH'(1) : abs_b;
    assign mq     = abs_a / div_bs;
    assign mr     = abs_a % div_bs;
    assign sq     = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? -mq : mq;
    assign sr     = a_i[WIDTH-1] ? -mr : mr;

    // Select the result for the requested op; unknown ops leave {hi,lo} unchanged
    always_comb begin
        hilo_o = hilo_i;
        case (op_i)
            MD_OP_MULT:  hilo_o = prod_s;
            MD_OP_MULTU: hilo_o = prod_u;
            MD_OP_MADD:  hilo_o = hilo_i + prod_s;
            MD_OP_MADDU: hilo_o = hilo_i + prod_u;
            MD_OP_MSUB:  hilo_o = hilo_i - prod_s;
            MD_OP_MSUBU: hilo_o = hilo_i - prod_u;
            MD_OP_DIV:   hilo_o = (b_i == '0) ? {a_i, {WIDTH{1'b1}}} : {sr, sq};
            MD_OP_DIVU:  hilo_o = (b_i == '0) ? {a_i, {WIDTH{1'b1}}} : {ur, uq};
            MD_OP_MTHI:  hilo_o = {a_i, hilo_i[WIDTH-1:0]};
            MD_OP_MTLO:  hilo_o = {hilo_i[W2-1:WIDTH], a_i};
            default:     hilo_o = hilo_i;
        endcase
    end

endmodule

// File: rtl/md_unit_param.sv
// md_unit_param: HI/LO multiply/divide unit with configurable latencies, stall reporting and flush
module md_unit_param
    import md_unit_param_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_req_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e          state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] pend_q, calc_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    md_unit_param_calc #(.WIDTH(WIDTH)) u_calc (
        .op_i   (op_i),
        .a_i    (src_a_i),
        .b_i    (src_b_i),
        .hilo_i ({hi_q, lo_q}),
        .hilo_o (calc_d)
    );

    // Result is computed at acceptance and held in pend_q; HI/LO only change on commit or MTHI/MTLO
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                MD_IDLE: begin
                    if (start_i && !flush_i && md_is_multi(op_i)) begin
                        pend_q  <= calc_d;
                        cnt_q   <= md_is_div(op_i) ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state_q <= MD_RUN;
                        busy_q  <= 1'b1;
                    end else if (start_i && !flush_i && md_is_mt(op_i)) begin
                        {hi_q, lo_q} <= calc_d;
                    end
                end
                MD_RUN: begin
                    if (flush_i) begin
                        state_q <= MD_IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CW'(1)) begin
                        {hi_q, lo_q} <= pend_q;
                        state_q      <= MD_IDLE;
                        cnt_q        <= '0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign stall_req_o = busy_q | (start_i & md_is_multi(op_i));
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign hi_o        = hi_q;
    assign lo_o        = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// tb_md_unit_param: scoreboard-driven directed and random checks of md_unit_param (WIDTH=32, 5/10 cycles)
module tb_md_unit_param;
    import md_unit_param_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, stall_req, done;
    logic [31:0] hi, lo;

    int          n_vec = 0, n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] m = '0;
    logic [63:0] e;
    int          bc;
    bit          to;

    md_unit_param #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .op_i        (op),
        .src_a_i     (src_a),
        .src_b_i     (src_b),
        .flush_i     (flush),
        .busy_o      (busy),
        .stall_req_o (stall_req),
        .done_o      (done),
        .hi_o        (hi),
        .lo_o        (lo)
    );

    always #5 clk = ~clk;

    // Reference behaviour built on native 64-bit and int arithmetic
    function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] h);
        int          sa, sbv;
        longint      ps;
        logic [63:0] p_s, p_u;
        sa  = a;
        sbv = b;
        ps  = longint'(sa) * longint'(sbv);
        p_s = ps;
        p_u = {32'b0, a} * {32'b0, b};
        case (o)
            MD_OP_MULT:  return p_s;
            MD_OP_MULTU: return p_u;
            MD_OP_MADD:  return h + p_s;
            MD_OP_MADDU: return h + p_u;
            MD_OP_MSUB:  return h - p_s;
            MD_OP_MSUBU: return h - p_u;
            MD_OP_DIV: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, a};
                return {32'(sa % sbv), 32'(sa / sbv)};
            end
            MD_OP_DIVU:  return (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default:     return h;
        endcase
    endfunction

    // Called at a negedge: drives one request for one edge and records its expected {hi,lo}
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        start = 1'b1; op = o; src_a = a; src_b = b;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles until done, bounded so a stuck DUT cannot hang the run
    task automatic wait_done(output int cnt, output bit timeout);
        cnt = 0; timeout = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin timeout = 1'b0; break; end
            if (busy) cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, stall_req, hi, lo} !== '0) begin
            n_err++; $display("FAIL reset: got busy=%b done=%b stall=%b hi=%h lo=%h want all 0", busy, done, stall_req, hi, lo);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mthlo();
        issue(MD_OP_MTHI, 32'h1234_5678, 32'h0, {32'h1234_5678, 32'h0});
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo, busy, done} !== {e, 2'b00}) begin
            n_err++; $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b want %h busy=0 done=0", hi, lo, busy, done, e);
        end
        issue(MD_OP_MTLO, 32'h9ABC_DEF0, 32'h0, {32'h1234_5678, 32'h9ABC_DEF0});
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo, busy, done} !== {e, 2'b00}) begin
            n_err++; $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b want %h busy=0 done=0", hi, lo, busy, done, e);
        end
    endtask

    task automatic test_mult();
        start = 1'b1; op = MD_OP_MULT; #1;
        n_vec++;
        if (stall_req !== 1'b1) begin n_err++; $display("FAIL stall_mult: got %b want 1", stall_req); end
        op = MD_OP_MTHI; #1;
        n_vec++;
        if (stall_req !== 1'b0) begin n_err++; $display("FAIL stall_mthi: got %b want 0", stall_req); end
        start = 1'b0;
        @(negedge clk);
        issue(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA);
        wait_done(bc, to);
        n_vec++;
        if (to || bc != 5) begin n_err++; $display("FAIL mult_busy: got %0d cycles timeout=%b want 5", bc, to); end
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL mult: got %h want %h", {hi, lo}, e); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse: got %b want 0", done); end
        issue(MD_OP_MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA);
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL multu: got %h want %h timeout=%b", {hi, lo}, e, to); end
    endtask

    task automatic test_div();
        issue(MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        wait_done(bc, to);
        n_vec++;
        if (to || bc != 10) begin n_err++; $display("FAIL div_busy: got %0d cycles timeout=%b want 10", bc, to); end
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL div: got %h want %h", {hi, lo}, e); end
        issue(MD_OP_DIVU, 32'd7, 32'd2, {32'd1, 32'd3});
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL divu: got %h want %h timeout=%b", {hi, lo}, e, to); end
    endtask

    task automatic test_corner();
        issue(MD_OP_DIV, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL div0: got %h want %h timeout=%b", {hi, lo}, e, to); end
        issue(MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL div_ovf: got %h want %h timeout=%b", {hi, lo}, e, to); end
        issue(MD_OP_MTHI, 32'h0, 32'h0, {32'h0, m[31:0]});
        e = sb.pop_front(); m = e;
        issue(MD_OP_MTLO, 32'hFFFF_FFFF, 32'h0, {32'h0, 32'hFFFF_FFFF});
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL madd_setup: got %h want %h", {hi, lo}, e); end
        issue(MD_OP_MADDU, 32'd1, 32'd1, {32'd1, 32'd0});
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL maddu_carry: got %h want %h timeout=%b", {hi, lo}, e, to); end
    endtask

    task automatic test_flush();
        int dones;
        issue(MD_OP_DIV, 32'd100, 32'd7, m);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        e = sb.pop_front(); n_vec++;
        if ({busy, done, hi, lo} !== {2'b00, e}) begin
            n_err++; $display("FAIL flush_run: got busy=%b done=%b hilo=%h want busy=0 done=0 hilo=%h", busy, done, {hi, lo}, e);
        end
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_vec++;
        if (dones != 0 || {hi, lo} !== m) begin
            n_err++; $display("FAIL flush_nodone: got %0d done pulses hilo=%h want 0 pulses hilo=%h", dones, {hi, lo}, m);
        end
        start = 1'b1; op = MD_OP_MTHI; src_a = 32'h0BAD_0BAD; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        n_vec++;
        if ({hi, lo} !== m) begin n_err++; $display("FAIL flush_idle: got %h want %h", {hi, lo}, m); end
    endtask

    task automatic test_busy_start();
        issue(MD_OP_MULTU, 32'd6, 32'd7, {32'd0, 32'd42});
        n_vec++;
        if (stall_req !== 1'b1) begin
            n_err++; $display("FAIL stall_busy: got %b want 1", stall_req);
        end
        start = 1'b1; op = MD_OP_MTHI; src_a = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, to);
        n_vec++;
        if (to || bc != 4) begin n_err++; $display("FAIL busy_start_len: got %0d cycles timeout=%b want 4", bc, to); end
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL busy_start: got %h want %h", {hi, lo}, e); end
        start = 1'b1; op = 4'hF; src_a = 32'h5555_5555;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({busy, hi, lo} !== {1'b0, m}) begin
            n_err++; $display("FAIL bad_op: got busy=%b hilo=%h want busy=0 hilo=%h", busy, {hi, lo}, m);
        end
    endtask

    task automatic test_back_to_back();
        issue(MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL b2b_first: got %h want %h timeout=%b", {hi, lo}, e, to); end
        issue(MD_OP_MSUB, 32'd2, 32'd3, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done(bc, to);
        n_vec++;
        if (to || bc != 5) begin n_err++; $display("FAIL b2b_busy: got %0d cycles timeout=%b want 5", bc, to); end
        e = sb.pop_front(); m = e; n_vec++;
        if ({hi, lo} !== e) begin n_err++; $display("FAIL b2b_msub: got %h want %h", {hi, lo}, e); end
    endtask

    task automatic test_random();
        logic [3:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            o = 4'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 4) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue(o, a, b, model(o, a, b, m));
            wait_done(bc, to);
            n_vec++;
            if (to || bc != (md_is_div(o) ? 10 : 5)) begin
                n_err++; $display("FAIL rand_busy op=%0d: got %0d cycles timeout=%b", o, bc, to);
            end
            e = sb.pop_front(); m = e; n_vec++;
            if ({hi, lo} !== e) begin
                n_err++; $display("FAIL rand op=%0d a=%h b=%h: got %h want %h", o, a, b, {hi, lo}, e);
            end
        end
    endtask

    task automatic test_async_reset();
        issue(MD_OP_MULT, 32'hFFFF_FFFE, 32'd3, m);
        #2 reset = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, hi, lo} !== '0) begin
            n_err++; $display("FAIL async_reset: got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        sb.delete();
        m = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(MD_OP_MULT, 32'd6, 32'd7, {32'd0, 32'd42});
        wait_done(bc, to);
        e = sb.pop_front(); m = e; n_vec++;
        if (to || {hi, lo} !== e) begin n_err++; $display("FAIL post_reset_mult: got %h want %h timeout=%b", {hi, lo}, e, to); end
    endtask

    initial begin
        test_reset();
        test_mthlo();
        test_mult();
        test_div();
        test_corner();
        test_flush();
        test_busy_start();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
